nt_node_activity_monitor: RTL and testbench
===========================================

# nt_node_activity_monitor

Windowed activity monitor that sits directly downstream of an Nt_Node subcircuit and consumes its single-bit output net. Over a programmable window it counts cycles where the net is high and cycles where it toggles. It then flags the net as a rare-activation candidate, i.e. a possible trojan trigger. Results leave through a valid/ready report port to the benchmark collection logic.

## Interface
- `WINDOW_LEN`, default 1024: number of samples per measurement window; must be ≥ 2.
- `CNT_W`, default 11: width of the count fields. Widths below clog2(WINDOW_LEN+1) are legal; the counts then saturate.
- `RARE_THRESH`, default 4: rarity threshold applied to both counts.
- `I1470_clk` in 1: the single clock; all state updates on its rising edge.
- `I1477_rst` in 1: reset; synchronous and active-high.
- `start` in 1: request one measurement window; honoured only in IDLE.
- `node_in` in 1: the monitored subcircuit output net.
- `busy` out 1: high in ARM, COUNT and REPORT.
- `rpt_valid` out 1: report available.
- `rpt_ready` in 1: consumer accepts the report.
- `rpt_toggles` out CNT_W: number of window samples that differ from the preceding sample.
- `rpt_ones` out CNT_W: number of window samples equal to 1.
- `rpt_rare` out 1: rarity flag.

## Operation
- States: IDLE, ARM, COUNT, REPORT.
- IDLE → ARM when `start`=1; `start` is ignored in every other state.
- ARM (1 cycle):
  - capture `node_in` into `prev`;
  - clear both counters and the sample counter.
- COUNT (WINDOW_LEN cycles): each cycle sample `node_in` as `s`:
  - ones += `s`;
  - toggles += (`s` != `prev`);
  - `prev` ← `s`.
  - After the WINDOW_LEN-th sample → REPORT.
- Counters saturate at 2^CNT_W−1 and never wrap.
- `rpt_rare` = (toggles < RARE_THRESH) OR (ones < RARE_THRESH) OR (ones > WINDOW_LEN−RARE_THRESH).
  - Compute it on the unsaturated comparison domain: widen to clog2(WINDOW_LEN+1)+1 bits internally.
- REPORT:
  - `rpt_valid`=1; `rpt_*` are registered and stable until the handshake.
  - On `rpt_valid`&&`rpt_ready`: go to ARM if `start`=1 that cycle, else to IDLE.
- Reset (any state, including mid-COUNT or mid-REPORT):
  - state IDLE;
  - `busy`, `rpt_valid`, `rpt_rare`, `rpt_toggles`, `rpt_ones`, the counters and `prev` all 0;
  - the partial window is discarded with no report.
- Reset wins over `start` and over the handshake in the same cycle.

## Timing
- `start` sampled at edge k (IDLE) → ARM during cycle k+1, `busy`=1 from k+1.
- COUNT covers cycles k+2 … k+1+WINDOW_LEN.
- `rpt_valid`=1 from cycle k+2+WINDOW_LEN. Start-to-report latency is WINDOW_LEN+2 cycles.
- Handshake completes at the edge where both `rpt_valid` and `rpt_ready` are 1:
  - `rpt_valid` drops the next cycle, or ARM follows directly on restart.
  - No bubble beyond that single transition cycle.
- `rpt_ready` may be held high permanently; the report then lasts exactly one cycle.
- `node_in` must be synchronous to `I1470_clk`. The upstream stage is flop-driven; no synchronizer is included.

## Structure
- Package `nt_mon_pkg` holds:
  - `mon_state_t` enum (IDLE, ARM, COUNT, REPORT);
  - default parameter constants;
  - a width helper for the comparison domain.
- One sub-module, `nt_sat_counter` (parameter W; inputs clr, inc; output cnt; saturating). It is instantiated for toggles, ones and the window sample counter.
- The FSM, `prev` register, rarity compare and report registers live in the top.

## Test plan
- Constant 0, WINDOW_LEN=8, RARE_THRESH=2 → report after 10 cycles: toggles=0, ones=0, rare=1.
- ARM sample 1, then alternating 0,1,0,… for 8 samples → toggles=8, ones=4, rare=0.
- Backpressure: hold `rpt_ready`=0 for 5 cycles after `rpt_valid` → report fields constant throughout; accept on cycle 6; `start` held high causes ARM next cycle with counts cleared.
- Reset asserted in COUNT at sample 5 → next cycle IDLE, `busy`=0, `rpt_valid` never rises, all outputs 0.
- Saturation: WINDOW_LEN=16, CNT_W=3, alternating input → toggles=7, ones=7, rare=0 (true ones=8 within [2,14]).
- `start` pulsed during COUNT and REPORT → ignored; exactly one report per accepted IDLE start.

Source files
------------

// File: rtl/nt_mon_pkg.sv
// Shared types and constants for the Nt_Node activity monitor.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package nt_mon_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARM    = 2'd1,
    COUNT  = 2'd2,
    REPORT = 2'd3
  } mon_state_t;

  localparam int DEF_WINDOW_LEN  = 1024;
  localparam int DEF_CNT_W       = 11;
  localparam int DEF_RARE_THRESH = 4;

  // Width of the rarity comparison domain: one bit of headroom above
  // what is needed to hold a full-window count.
  function automatic int cmp_width(input int window_len);
    return $clog2(window_len + 1) + 1;
  endfunction

endpackage

// File: rtl/nt_sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
// Latency: count updates one cycle after inc.
// Backpressure: none; inc is ignored once saturated.
module nt_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  // Clear has priority over increment; hold at the maximum value.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/nt_node_activity_monitor.sv
// Windowed high/toggle counter on a single net, flagging rare activation.
// Latency: report valid WINDOW_LEN+2 cycles after an accepted start.
// Backpressure: report held stable until rpt_valid && rpt_ready.
module nt_node_activity_monitor
  import nt_mon_pkg::*;
#(
  parameter int WINDOW_LEN  = DEF_WINDOW_LEN,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int RARE_THRESH = DEF_RARE_THRESH
) (
  input  logic             I1470_clk,
  input  logic             I1477_rst,
  input  logic             start,
  input  logic             node_in,
  output logic             busy,
  output logic             rpt_valid,
  input  logic             rpt_ready,
  output logic [CNT_W-1:0] rpt_toggles,
  output logic [CNT_W-1:0] rpt_ones,
  output logic             rpt_rare
);

  // Internal counters are wide enough for a full window so that the rarity
  // test sees true counts; only the reported fields saturate to CNT_W.
  localparam int CW = $clog2(WINDOW_LEN + 1);
  localparam int XW = cmp_width(WINDOW_LEN);
  localparam longint SAT_MAX = (64'd1 << CNT_W) - 1;

  mon_state_t    state;
  logic          prev;
  logic [CW-1:0] tog_cnt;
  logic [CW-1:0] ones_cnt;
  logic [CW-1:0] smp_cnt;

  logic          in_count;
  logic          samp_tog;
  logic          last_sample;
  logic [CW-1:0] tog_fin;
  logic [CW-1:0] ones_fin;
  logic [XW-1:0] tog_x;
  logic [XW-1:0] ones_x;
  logic          rare_fin;

  assign in_count    = (state == COUNT);
  assign samp_tog    = (node_in != prev);
  assign last_sample = in_count && (smp_cnt == CW'(WINDOW_LEN - 1));

  nt_sat_counter #(.W(CW)) u_tog_cnt (
    .clk (I1470_clk),
    .rst (I1477_rst),
    .clr (state == ARM),
    .inc (in_count && samp_tog),
    .cnt (tog_cnt)
  );

  nt_sat_counter #(.W(CW)) u_ones_cnt (
    .clk (I1470_clk),
    .rst (I1477_rst),
    .clr (state == ARM),
    .inc (in_count && node_in),
    .cnt (ones_cnt)
  );

  nt_sat_counter #(.W(CW)) u_smp_cnt (
    .clk (I1470_clk),
    .rst (I1477_rst),
    .clr (state == ARM),
    .inc (in_count),
    .cnt (smp_cnt)
  );

  // Clamp a full-range count into the report field width.
  function automatic logic [CNT_W-1:0] sat_rpt(input logic [CW-1:0] v);
    if ((CNT_W < CW) && (longint'(v) > SAT_MAX)) begin
      return '1;
    end
    return CNT_W'(v);
  endfunction

  // Final counts include the sample taken on the last window cycle, so the
  // report can be registered on the same edge that leaves COUNT.
  always_comb begin
    tog_fin  = tog_cnt + CW'(samp_tog);
    ones_fin = ones_cnt + CW'(node_in);
    tog_x    = XW'(tog_fin);
    ones_x   = XW'(ones_fin);
    rare_fin = (tog_x < XW'(RARE_THRESH)) ||
               (ones_x < XW'(RARE_THRESH)) ||
               (ones_x > XW'(WINDOW_LEN - RARE_THRESH));
  end

  // Control FSM with registered busy/report outputs and the prev-sample flop.
  always_ff @(posedge I1470_clk) begin
    if (I1477_rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      rpt_valid   <= 1'b0;
      rpt_rare    <= 1'b0;
      rpt_toggles <= '0;
      rpt_ones    <= '0;
      prev        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= ARM;
            busy  <= 1'b1;
          end
        end
        ARM: begin
          prev  <= node_in;
          state <= COUNT;
        end
        COUNT: begin
          prev <= node_in;
          if (last_sample) begin
            state       <= REPORT;
            rpt_valid   <= 1'b1;
            rpt_toggles <= sat_rpt(tog_fin);
            rpt_ones    <= sat_rpt(ones_fin);
            rpt_rare    <= rare_fin;
          end
        end
        REPORT: begin
          if (rpt_ready) begin
            rpt_valid <= 1'b0;
            if (start) begin
              state <= ARM;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nt_node_activity_monitor.sv
// Directed bench: dut_a (WINDOW_LEN=8) for function/handshake/reset,
// dut_b (WINDOW_LEN=16, CNT_W=3) for report-field saturation.
module tb_nt_node_activity_monitor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rst, a_start, a_node, a_ready;
  logic        a_busy, a_valid, a_rare;
  logic [10:0] a_tog, a_ones;

  logic        b_rst, b_start, b_node, b_ready;
  logic        b_busy, b_valid, b_rare;
  logic [2:0]  b_tog, b_ones;

  int checks = 0;
  int errors = 0;
  int a_acc  = 0;

  nt_node_activity_monitor #(
    .WINDOW_LEN (8),
    .CNT_W      (11),
    .RARE_THRESH(2)
  ) dut_a (
    .I1470_clk  (clk),
    .I1477_rst  (a_rst),
    .start      (a_start),
    .node_in    (a_node),
    .busy       (a_busy),
    .rpt_valid  (a_valid),
    .rpt_ready  (a_ready),
    .rpt_toggles(a_tog),
    .rpt_ones   (a_ones),
    .rpt_rare   (a_rare)
  );

  nt_node_activity_monitor #(
    .WINDOW_LEN (16),
    .CNT_W      (3),
    .RARE_THRESH(2)
  ) dut_b (
    .I1470_clk  (clk),
    .I1477_rst  (b_rst),
    .start      (b_start),
    .node_in    (b_node),
    .busy       (b_busy),
    .rpt_valid  (b_valid),
    .rpt_ready  (b_ready),
    .rpt_toggles(b_tog),
    .rpt_ones   (b_ones),
    .rpt_rare   (b_rare)
  );

  // Count accepted reports on dut_a.
  always @(posedge clk) begin
    if (!a_rst && a_valid && a_ready) a_acc++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Called at a negedge in IDLE; returns at the negedge of the ARM cycle.
  task automatic a_start_pulse();
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
  endtask

  // Drive the ARM-cycle value, then n window samples (LSB first).
  task automatic a_feed(input logic arm_bit, input logic [7:0] pat, input int n);
    a_node = arm_bit;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      a_node = pat[i];
    end
  endtask

  task automatic a_wait_valid(output int cyc);
    cyc = 0;
    while (a_valid !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    if (a_valid !== 1'b1) check("a_valid_timeout", {31'd0, a_valid}, 32'd1);
  endtask

  task automatic a_check_rpt(input string tag, input int tog, input int ones, input logic rare);
    check({tag, "_toggles"}, {21'd0, a_tog}, tog);
    check({tag, "_ones"}, {21'd0, a_ones}, ones);
    check({tag, "_rare"}, {31'd0, a_rare}, {31'd0, rare});
  endtask

  task automatic a_accept();
    a_ready = 1'b1;
    @(negedge clk);
    a_ready = 1'b0;
  endtask

  initial begin
    int   cyc;
    logic seen;

    a_rst = 1'b1; a_start = 1'b0; a_node = 1'b0; a_ready = 1'b0;
    b_rst = 1'b1; b_start = 1'b0; b_node = 1'b0; b_ready = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_busy", {31'd0, a_busy}, 0);
    check("rst_valid", {31'd0, a_valid}, 0);
    check("rst_toggles", {21'd0, a_tog}, 0);
    check("rst_ones", {21'd0, a_ones}, 0);
    check("rst_rare", {31'd0, a_rare}, 0);
    check("rst_b_busy", {31'd0, b_busy}, 0);
    check("rst_b_valid", {31'd0, b_valid}, 0);
    a_rst = 1'b0;
    b_rst = 1'b0;
    @(negedge clk);

    // Constant 0: latency 10 cycles from the start cycle, all-zero counts, rare
    a_start_pulse();
    check("t1_arm_busy", {31'd0, a_busy}, 1);
    check("t1_arm_valid", {31'd0, a_valid}, 0);
    a_feed(1'b0, 8'h00, 8);
    a_wait_valid(cyc);
    check("t1_latency", 8 + cyc, 9);
    a_check_rpt("t1", 0, 0, 1'b1);
    a_accept();
    check("t1_done_busy", {31'd0, a_busy}, 0);
    check("t1_done_valid", {31'd0, a_valid}, 0);

    // ARM sample 1, then 0,1,0,1,... : toggles 8, ones 4, not rare
    a_start_pulse();
    a_feed(1'b1, 8'hAA, 8);
    a_wait_valid(cyc);
    a_check_rpt("t2", 8, 4, 1'b0);

    // Backpressure: fields stable for 5 cycles, accept with start -> ARM
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t3_hold_valid", {31'd0, a_valid}, 1);
      a_check_rpt("t3_hold", 8, 4, 1'b0);
    end
    a_ready = 1'b1;
    a_start = 1'b1;
    @(negedge clk);
    a_ready = 1'b0;
    a_start = 1'b0;
    check("t3_restart_busy", {31'd0, a_busy}, 1);
    check("t3_restart_valid", {31'd0, a_valid}, 0);
    // Counts cleared: a fresh all-ones window reports 8 ones, not 12
    a_feed(1'b1, 8'hFF, 8);
    a_wait_valid(cyc);
    a_check_rpt("t3b", 0, 8, 1'b1);
    a_accept();

    // start held through ARM/COUNT/REPORT is ignored; one report only
    a_start_pulse();
    a_start = 1'b1;
    a_feed(1'b0, 8'h36, 8);
    a_wait_valid(cyc);
    a_check_rpt("t6", 4, 4, 1'b0);
    repeat (3) @(negedge clk);
    check("t6_still_valid", {31'd0, a_valid}, 1);
    a_start = 1'b0;
    a_accept();
    check("t6_idle_busy", {31'd0, a_busy}, 0);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (a_valid || a_busy) seen = 1'b1;
    end
    check("t6_no_second_window", {31'd0, seen}, 0);

    // Reset mid-COUNT: everything cleared, no report appears
    a_start_pulse();
    a_feed(1'b0, 8'h3F, 5);
    a_rst = 1'b1;
    @(negedge clk);
    check("t4_busy", {31'd0, a_busy}, 0);
    check("t4_valid", {31'd0, a_valid}, 0);
    check("t4_toggles", {21'd0, a_tog}, 0);
    check("t4_ones", {21'd0, a_ones}, 0);
    check("t4_rare", {31'd0, a_rare}, 0);
    a_rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (a_valid) seen = 1'b1;
    end
    check("t4_no_report", {31'd0, seen}, 0);
    check("a_accept_count", a_acc, 4);

    // Saturation on dut_b: true toggles 16, ones 8 -> fields 7/7, not rare
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    b_node = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      b_node = (i % 2 == 1);
    end
    cyc = 0;
    while (b_valid !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("t5_latency", 16 + cyc, 17);
    check("t5_toggles", {29'd0, b_tog}, 7);
    check("t5_ones", {29'd0, b_ones}, 7);
    check("t5_rare", {31'd0, b_rare}, 0);
    b_ready = 1'b1;
    @(negedge clk);
    b_ready = 1'b0;
    check("t5_done_valid", {31'd0, b_valid}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
